// File: rtl/clock_period_gen.sv
// clock_period_gen: per-edge time increment generator for the gated-clock block.
// Produces inc = nominal period + fractional-offset carry (+ optional LFSR jitter),
// advancing once per accepted edge (time_eq) while running. New configuration is
// taken through a valid/ready handshake into shadow registers and only becomes
// active on an edge boundary (or immediately, one cycle later, while idle).
// Optional feature macro: JITTER_EN (adds the 32-bit Galois LFSR jitter term).
module clock_period_gen #(
  parameter int          TIME_INC_BITS = 16,
  parameter int          FRAC_BITS     = 16,
  parameter int          JIT_BITS      = 8,
  parameter int          PERIOD_RST    = 1000,
  parameter logic [31:0] LFSR_SEED     = 32'h1
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     time_eq,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [TIME_INC_BITS-1:0] cfg_period,
  input  logic [FRAC_BITS-1:0]     cfg_frac,
  input  logic [JIT_BITS-1:0]      cfg_jmask,
  output logic [TIME_INC_BITS-1:0] inc,
  output logic [31:0]              edge_cnt,
  output logic                     cfg_busy
);

  // Signed working width: one bit of headroom for period+carry+jitter, one sign bit.
  localparam int SW = TIME_INC_BITS + 2;

  localparam logic [TIME_INC_BITS-1:0] PERIOD_RST_V = TIME_INC_BITS'(PERIOD_RST);
  localparam logic [TIME_INC_BITS-1:0] PERIOD_ONE   = {{(TIME_INC_BITS-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0]     SUM_ONE      = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0]     SUM_MAX      = {2'b00, {TIME_INC_BITS{1'b1}}};

  // A zero seed would lock the LFSR at zero forever.
  if (LFSR_SEED == 32'd0) begin : g_seed_check
    $error("clock_period_gen: LFSR_SEED must be nonzero");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Active and shadow configuration
  logic [TIME_INC_BITS-1:0] active_period;
  logic [FRAC_BITS-1:0]     active_frac;
  logic [TIME_INC_BITS-1:0] shadow_period;
  logic [FRAC_BITS-1:0]     shadow_frac;

  logic [FRAC_BITS-1:0]     frac_acc;

  // Datapath intermediates
  logic                     cfg_xfer;
  logic                     in_run;
  logic                     edge_adv;
  logic                     apply;
  logic [TIME_INC_BITS-1:0] use_period;
  logic [FRAC_BITS-1:0]     use_frac;
  logic [TIME_INC_BITS-1:0] eff_period;
  logic [FRAC_BITS:0]       acc_sum;
  logic                     carry;
  logic signed [SW-1:0]     jit_ext;
  logic signed [SW-1:0]     sum;
  logic [TIME_INC_BITS-1:0] edge_inc;

  assign cfg_xfer = cfg_valid & cfg_ready;
  assign in_run   = (state == RUN);
  // en gates the edge too, so the single RUN cycle after en drops is already frozen.
  assign edge_adv = in_run & en & time_eq;
  // Idle applies a pending shadow at once; running waits for an accepted edge.
  assign apply    = cfg_busy & (~in_run | edge_adv);

  // FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state: follow en with one cycle of latency
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en)  state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef JITTER_EN
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic [JIT_BITS-1:0] active_jmask;
  logic [JIT_BITS-1:0] shadow_jmask;
  logic [JIT_BITS-1:0] use_jmask;
  logic [JIT_BITS-1:0] jit_masked;
  logic signed [JIT_BITS:0] jit_small;
  logic [31:0]         lfsr;
  logic [31:0]         lfsr_step;

  assign use_jmask  = apply ? shadow_jmask : active_jmask;
  assign jit_masked = lfsr[JIT_BITS-1:0] & use_jmask;
  // Centre the masked sample around zero: range [-(m>>1), m-(m>>1)].
  assign jit_small  = $signed({1'b0, jit_masked}) - $signed({1'b0, (use_jmask >> 1)});
  assign jit_ext    = {{(SW-JIT_BITS-1){jit_small[JIT_BITS]}}, jit_small};
  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  assign lfsr_step  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);

  // Jitter configuration shadow/active registers and LFSR advance per edge
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      active_jmask <= '0;
      shadow_jmask <= '0;
      lfsr         <= LFSR_SEED;
    end else begin
      if (cfg_xfer) shadow_jmask <= cfg_jmask;
      if (apply)    active_jmask <= shadow_jmask;
      if (edge_adv) lfsr         <= lfsr_step;
    end
  end
`else
  // Jitter mask is accepted on the handshake but has no effect in this build.
  logic unused_jmask;
  assign unused_jmask = ^cfg_jmask;
  assign jit_ext      = '0;
`endif

  // Next-edge arithmetic: pick the config this edge uses, add carry and jitter, clamp
  always_comb begin
    use_period = apply ? shadow_period : active_period;
    use_frac   = apply ? shadow_frac   : active_frac;
    eff_period = (use_period == '0) ? PERIOD_ONE : use_period;
    acc_sum    = {1'b0, frac_acc} + {1'b0, use_frac};
    carry      = acc_sum[FRAC_BITS];
    sum        = $signed({2'b00, eff_period}) + $signed({{(SW-1){1'b0}}, carry}) + jit_ext;
    edge_inc   = sum[TIME_INC_BITS-1:0];
    // inc must never be zero, otherwise the clock block would fire time_eq twice in a row
    if (sum < SUM_ONE)      edge_inc = PERIOD_ONE;
    else if (sum > SUM_MAX) edge_inc = SUM_MAX[TIME_INC_BITS-1:0];
  end

  // Config handshake: capture into shadow, release ready once the shadow is applied
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shadow_period <= PERIOD_RST_V;
      shadow_frac   <= '0;
      active_period <= PERIOD_RST_V;
      active_frac   <= '0;
      cfg_ready     <= 1'b1;
      cfg_busy      <= 1'b0;
    end else if (cfg_xfer) begin
      shadow_period <= cfg_period;
      shadow_frac   <= cfg_frac;
      cfg_ready     <= 1'b0;
      cfg_busy      <= 1'b1;
    end else if (apply) begin
      active_period <= shadow_period;
      active_frac   <= shadow_frac;
      cfg_ready     <= 1'b1;
      cfg_busy      <= 1'b0;
    end
  end

  // Per-edge state: increment, phase accumulator, edge counter
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      inc      <= PERIOD_RST_V;
      frac_acc <= '0;
      edge_cnt <= '0;
    end else if (edge_adv) begin
      inc      <= edge_inc;
      frac_acc <= acc_sum[FRAC_BITS-1:0];
      edge_cnt <= edge_cnt + 32'd1;
    end else if (!in_run) begin
      // Idle holds inc at the plain nominal period, picking up any pending config
      inc      <= eff_period;
    end
  end

endmodule
